// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide unit: datapath width,
// iteration count, funct3 operation encodings, FSM state encoding and small
// operand helpers used by muldiv_unit and div_step.
// Configuration macro: MULDIV_DIV_EN (divider present when defined).
// ---------------------------------------------------------------------------
package muldiv_pkg;

   localparam int XLEN       = 32;
   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = 6;   // must hold the value ITER_COUNT

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Operand A is read as two's complement for these ops.
   function automatic logic op_a_signed(input op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   // Operand B is read as two's complement for these ops.
   function automatic logic op_b_signed(input op_e op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_div_op(input op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem_op(input op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v,
                                                  input logic            neg);
      return neg ? (~v + XLEN'(1)) : v;
   endfunction

endpackage : muldiv_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational step of unsigned restoring division. The next dividend
// bit is taken from the MSB of quo_in and shifted into the partial remainder;
// if the divisor fits, it is subtracted and a 1 enters the quotient LSB.
// Only instantiated when MULDIV_DIV_EN is defined.
//   rem_in   partial remainder before the step
//   quo_in   remaining dividend bits (MSB first) / quotient bits so far
//   divisor  divisor magnitude
//   rem_out  partial remainder after the step
//   quo_out  quo_in shifted left with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module div_step
   import muldiv_pkg::*;
(
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          fits;

   always_comb begin
      // 33 bits: the shifted remainder can reach twice the divisor.
      shifted = {rem_in, quo_in[XLEN-1]};
      diff    = shifted - {1'b0, divisor};
      fits    = (shifted >= {1'b0, divisor});
      rem_out = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], fits};
   end

endmodule : div_step

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit with a fixed 33-cycle latency from the
// edge that accepts start to the single-cycle done strobe.
// Configuration macro: MULDIV_DIV_EN. When undefined, the divider is left
// out and DIV/DIVU/REM/REMU complete with the same latency and result 0.
// Ports:
//   clk        clock, all state changes on its rising edge
//   reset      asynchronous active-low reset
//   start      request strobe, sampled only in IDLE
//   kill       flush: back to IDLE at the next edge, beats start
//   funct3     RV32M operation select
//   rs1Data    operand A
//   rs2Data    operand B
//   rdAddrIn   destination register tag, latched with the operands
//   busy       high while the operation iterates
//   done       one-cycle result-valid strobe (register-file write enable)
//   result     result value, zero whenever done is low
//   rdAddrOut  latched destination tag
// ---------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1Data,
   input  logic [XLEN-1:0] rs2Data,
   input  logic [4:0]      rdAddrIn,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rdAddrOut
);

   // Multiply: acc = {partial product high, multiplier shifting out}.
   // Divide:   acc = {partial remainder, dividend shifting out / quotient}.
   state_e            state_q,   state_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [2*XLEN-1:0] acc_q,     acc_d;
   logic [XLEN-1:0]   opb_q,     opb_d;     // multiplicand or divisor magnitude
   op_e               op_q,      op_d;
   logic              neg_q,     neg_d;     // final result must be negated
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic [XLEN-1:0]   result_q,  result_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
`ifdef MULDIV_DIV_EN
   logic [XLEN-1:0]   rs1_q,     rs1_d;     // raw A, the remainder on divide-by-zero
   logic              div0_q,    div0_d;
`endif

   // ---------------- operand decode at accept time ----------------
   op_e             op_in;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      op_in = op_e'(funct3);
      a_neg = op_a_signed(op_in) && rs1Data[XLEN-1];
      b_neg = op_b_signed(op_in) && rs2Data[XLEN-1];
      mag_a = negate_if(rs1Data, a_neg);
      mag_b = negate_if(rs2Data, b_neg);
   end

   // ---------------- one shift-add multiply step ----------------
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] div_next;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
   end

   // ---------------- one restoring divide step ----------------
`ifdef MULDIV_DIV_EN
   logic [XLEN-1:0] div_rem, div_quo;

   div_step u_div_step (
      .rem_in  (acc_q[2*XLEN-1:XLEN]),
      .quo_in  (acc_q[XLEN-1:0]),
      .divisor (opb_q),
      .rem_out (div_rem),
      .quo_out (div_quo)
   );

   assign div_next = {div_rem, div_quo};
`else
   // No divider: the accumulator just idles through the 32 iterations.
   assign div_next = acc_q;
`endif

   // ---------------- sign fix-up and result select ----------------
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   final_res;

   always_comb begin
      prod      = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
      final_res = '0;
      case (op_q)
         OP_MUL:                       final_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
         OP_DIV, OP_DIVU:
            final_res = div0_q ? '1 : negate_if(acc_q[XLEN-1:0], neg_q);
         OP_REM, OP_REMU:
            final_res = div0_q ? rs1_q : negate_if(acc_q[2*XLEN-1:XLEN], neg_q);
`endif
         default:                      final_res = '0;
      endcase
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      // NOTE: every _d defaults to its _q first, so no branch can leave a
      // signal unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      op_d      = op_q;
      neg_d     = neg_q;
      busy_d    = busy_q;
      done_d    = done_q;
      result_d  = result_q;
      rd_addr_d = rd_addr_q;
`ifdef MULDIV_DIV_EN
      rs1_d     = rs1_q;
      div0_d    = div0_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start && !kill) begin
               state_d   = ST_CALC;
               busy_d    = 1'b1;
               cnt_d     = '0;
               op_d      = op_in;
               rd_addr_d = rdAddrIn;
               // Quotient sign is sign(A)^sign(B); remainder follows A.
               neg_d     = is_rem_op(op_in) ? a_neg : (a_neg ^ b_neg);
               if (is_div_op(op_in)) begin
                  acc_d = {{XLEN{1'b0}}, mag_a};
                  opb_d = mag_b;
               end else begin
                  acc_d = {{XLEN{1'b0}}, mag_b};
                  opb_d = mag_a;
               end
`ifdef MULDIV_DIV_EN
               rs1_d  = rs1Data;
               div0_d = (rs2Data == '0);
`endif
            end
         end

         ST_CALC: begin
            if (kill) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(ITER_COUNT)) begin
               // All iterations done; this extra edge applies the sign fix.
               state_d  = ST_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               result_d = final_res;
            end else begin
               acc_d = is_div_op(op_q) ? div_next : mul_next;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            // Leaves unconditionally; a kill here has the same effect.
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = '0;
         end

         default: begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = '0;
         end
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         op_q      <= OP_MUL;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         rd_addr_q <= '0;
`ifdef MULDIV_DIV_EN
         rs1_q     <= '0;
         div0_q    <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, regardless of statement order.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
         rd_addr_q <= rd_addr_d;
`ifdef MULDIV_DIV_EN
         rs1_q     <= rs1_d;
         div0_q    <= div0_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign rdAddrOut = rd_addr_q;

endmodule : muldiv_unit
